// File: rtl/chien_search.sv
// rtl/chien_search.sv - Chien search root locator for binary BCH codes over GF(2^6/2^8/2^10)
//
// Evaluates the error locator L(x) = 1 + s1*x + s2*x^2 + s3*x^3 + s4*x^4 at
// x = alpha^(-p) for p = 0..n-1, one position per clock, and reports every
// root as an error position in ascending order.
//
// Ports:
//   clk              sole clock, rising edge
//   rst              synchronous active-high reset
//   start            one-cycle search request, accepted only while busy=0
//   code[1:0]        field select: 1 -> GF(2^6)/n=63, 2 -> GF(2^8)/n=255,
//                    0 or 3 -> GF(2^10)/n=1023
//   deg[2:0]         locator degree (0..4)
//   sigma1..sigma4   locator coefficients, polynomial basis, bits >= m ignored
//   busy             search in progress
//   loc_valid/loc    one-cycle pulse and error position per root found
//   done             one-cycle end-of-search pulse
//   err_cnt[2:0]     roots found (saturates at 4), held until next start
//   fail             decoding failure, valid with done, held until next start
module chien_search (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] code,
    input  logic [2:0] deg,
    input  logic [9:0] sigma1,
    input  logic [9:0] sigma2,
    input  logic [9:0] sigma3,
    input  logic [9:0] sigma4,
    output logic       busy,
    output logic       loc_valid,
    output logic [9:0] loc,
    output logic       done,
    output logic [2:0] err_cnt,
    output logic       fail
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SRCH = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] code_q;
    logic [2:0] deg_q;
    logic [9:0] r1, r2, r3, r4;
    logic [9:0] pos;
    logic       flush;      // cycle n: last root result drains before DONE
    logic       ovf;        // a fifth root was seen

    // Keep only the low m bits of a field element.
    function automatic logic [9:0] mask_m(input logic [9:0] x, input logic [1:0] c);
        logic [9:0] mask;
        case (c)
            2'd1:    mask = 10'h03F;
            2'd2:    mask = 10'h0FF;
            default: mask = 10'h3FF;
        endcase
        return x & mask;
    endfunction

    // Multiply by alpha^(-1): shift right, folding in the field polynomial
    // (shifted right by one) whenever the constant term is set.
    function automatic logic [9:0] div_alpha(input logic [9:0] x, input logic [1:0] c);
        logic [9:0] ph;
        case (c)
            2'd1:    ph = 10'h021;
            2'd2:    ph = 10'h08E;
            default: ph = 10'h204;
        endcase
        return {1'b0, x[9:1]} ^ (x[0] ? ph : 10'h000);
    endfunction

    logic [9:0] lsum;
    logic       root;
    logic [9:0] pos_last;
    logic [9:0] r1_nxt, r2_nxt, r3_nxt, r4_nxt;

    always_comb begin
        lsum   = 10'h001 ^ r1 ^ r2 ^ r3 ^ r4;
        root   = (lsum == 10'h000);
        case (code_q)
            2'd1:    pos_last = 10'd62;
            2'd2:    pos_last = 10'd254;
            default: pos_last = 10'd1022;
        endcase
        r1_nxt = div_alpha(r1, code_q);
        r2_nxt = div_alpha(div_alpha(r2, code_q), code_q);
        r3_nxt = div_alpha(div_alpha(div_alpha(r3, code_q), code_q), code_q);
        r4_nxt = div_alpha(div_alpha(div_alpha(div_alpha(r4, code_q), code_q), code_q), code_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            code_q    <= 2'd0;
            deg_q     <= 3'd0;
            r1        <= 10'd0;
            r2        <= 10'd0;
            r3        <= 10'd0;
            r4        <= 10'd0;
            pos       <= 10'd0;
            flush     <= 1'b0;
            ovf       <= 1'b0;
            busy      <= 1'b0;
            loc_valid <= 1'b0;
            loc       <= 10'd0;
            done      <= 1'b0;
            err_cnt   <= 3'd0;
            fail      <= 1'b0;
        end else begin
            loc_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        code_q  <= code;
                        deg_q   <= deg;
                        r1      <= mask_m(sigma1, code);
                        r2      <= mask_m(sigma2, code);
                        r3      <= mask_m(sigma3, code);
                        r4      <= mask_m(sigma4, code);
                        pos     <= 10'd0;
                        flush   <= 1'b0;
                        ovf     <= 1'b0;
                        err_cnt <= 3'd0;
                        fail    <= 1'b0;
                        busy    <= 1'b1;
                        state   <= SRCH;
                    end else begin
                        state <= IDLE;
                    end
                end
                SRCH: begin
                    if (!flush) begin
                        if (root) begin
                            loc_valid <= 1'b1;
                            loc       <= pos;
                            if (err_cnt == 3'd4) begin
                                ovf  <= 1'b1;
                                fail <= 1'b1;
                            end else begin
                                err_cnt <= err_cnt + 3'd1;
                            end
                        end
                        r1 <= r1_nxt;
                        r2 <= r2_nxt;
                        r3 <= r3_nxt;
                        r4 <= r4_nxt;
                        if (pos == pos_last) begin
                            flush <= 1'b1;
                        end else begin
                            pos <= pos + 10'd1;
                        end
                    end else begin
                        flush <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        fail  <= (err_cnt != deg_q) || ovf;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chien_search.sv
// tb/tb_chien_search.sv - directed self-checking bench for chien_search
module tb_chien_search;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] code;
    logic [2:0] deg;
    logic [9:0] sigma1, sigma2, sigma3, sigma4;
    logic       busy, loc_valid, done, fail;
    logic [9:0] loc;
    logic [2:0] err_cnt;

    int checks = 0;
    int errors = 0;

    chien_search dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .code      (code),
        .deg       (deg),
        .sigma1    (sigma1),
        .sigma2    (sigma2),
        .sigma3    (sigma3),
        .sigma4    (sigma4),
        .busy      (busy),
        .loc_valid (loc_valid),
        .loc       (loc),
        .done      (done),
        .err_cnt   (err_cnt),
        .fail      (fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Launch a search from a negedge, follow it cycle by cycle through the
    // done cycle (n+1) and compare against hand-derived root positions.
    // Returns at the negedge of the done cycle so the next call starts there.
    task automatic run_search(input string tag, input logic [1:0] c, input logic [2:0] d,
                              input logic [9:0] s1, input logic [9:0] s2,
                              input logic [9:0] s3, input logic [9:0] s4,
                              input int l0, input int l1, input int l2, input int l3,
                              input int ecnt, input logic efail);
        int exp_l[4];
        int n, idx, done_cyc, busy_bad, cyc_bad;
        logic [2:0] cnt_d;
        logic       fail_d;
        exp_l[0] = l0; exp_l[1] = l1; exp_l[2] = l2; exp_l[3] = l3;
        n = (c == 2'd1) ? 63 : (c == 2'd2) ? 255 : 1023;
        idx = 0; done_cyc = -1; busy_bad = 0; cyc_bad = 0;
        cnt_d = 3'd7; fail_d = 1'bx;
        code = c; deg = d; sigma1 = s1; sigma2 = s2; sigma3 = s3; sigma4 = s4;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Scramble inputs after acceptance; the search must not notice.
        code = ~c; deg = ~d; sigma1 = ~s1; sigma2 = ~s2; sigma3 = ~s3; sigma4 = ~s4;
        for (int k = 0; k <= n + 1; k++) begin
            @(negedge clk);
            if (busy !== ((k <= n) ? 1'b1 : 1'b0)) busy_bad++;
            if (loc_valid === 1'b1) begin
                if (idx < 4) begin
                    check({tag, " loc"}, {22'd0, loc}, exp_l[idx]);
                    if (k != exp_l[idx] + 1) cyc_bad++;
                end else begin
                    check({tag, " extra root"}, idx, ecnt);
                end
                idx++;
            end
            if (done === 1'b1 && done_cyc < 0) begin
                done_cyc = k;
                cnt_d    = err_cnt;
                fail_d   = fail;
            end
        end
        check({tag, " root count"}, idx, ecnt);
        check({tag, " loc cycle errs"}, cyc_bad, 0);
        check({tag, " done cycle"}, done_cyc, n + 1);
        check({tag, " busy errs"}, busy_bad, 0);
        check({tag, " err_cnt"}, {29'd0, cnt_d}, ecnt);
        check({tag, " fail"}, {31'd0, fail_d}, {31'd0, efail});
    endtask

    initial begin
        int pulses, done_seen, busy_seen;
        rst = 1'b1; start = 1'b0; code = 2'd0; deg = 3'd0;
        sigma1 = 10'd0; sigma2 = 10'd0; sigma3 = 10'd0; sigma4 = 10'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset busy", {31'd0, busy}, 0);
        check("reset loc_valid", {31'd0, loc_valid}, 0);
        check("reset loc", {22'd0, loc}, 0);
        check("reset done", {31'd0, done}, 0);
        check("reset err_cnt", {29'd0, err_cnt}, 0);
        check("reset fail", {31'd0, fail}, 0);

        // No roots, then back-to-back searches started in each done cycle.
        run_search("zero", 2'd1, 3'd0, 10'h000, 10'h000, 10'h000, 10'h000, -1, -1, -1, -1, 0, 1'b0);
        run_search("a5", 2'd1, 3'd1, 10'h020, 10'h000, 10'h000, 10'h000, 5, -1, -1, -1, 1, 1'b0);
        run_search("gf256", 2'd2, 3'd2, 10'h003, 10'h002, 10'h000, 10'h000, 0, 1, -1, -1, 2, 1'b0);
        run_search("degmis", 2'd1, 3'd2, 10'h020, 10'h000, 10'h000, 10'h000, 5, -1, -1, -1, 1, 1'b1);
        @(negedge clk);
        // Upper bits above m=6 must be dropped: 0x3E0 -> alpha^5.
        run_search("mask", 2'd1, 3'd1, 10'h3E0, 10'h000, 10'h000, 10'h000, 5, -1, -1, -1, 1, 1'b0);
        // alpha^-1 = alpha^5+1 in GF(64): root at last position 62.
        run_search("last", 2'd1, 3'd1, 10'h021, 10'h000, 10'h000, 10'h000, 62, -1, -1, -1, 1, 1'b0);
        // (1+x)(1+ax)(1+a^2x) and (..)(1+a^3x) in GF(64).
        run_search("deg3", 2'd1, 3'd3, 10'h007, 10'h00E, 10'h008, 10'h000, 0, 1, 2, -1, 3, 1'b0);
        run_search("deg4", 2'd1, 3'd4, 10'h00F, 10'h036, 10'h03B, 10'h003, 0, 1, 2, 3, 4, 1'b0);
        run_search("nozero", 2'd1, 3'd3, 10'h000, 10'h000, 10'h000, 10'h000, -1, -1, -1, -1, 0, 1'b1);
        // code 0 selects GF(1024), root alpha^-1 -> position 1.
        run_search("code0", 2'd0, 3'd1, 10'h002, 10'h000, 10'h000, 10'h000, 1, -1, -1, -1, 1, 1'b0);

        // Long search, ignored second start, abort by reset.
        @(negedge clk);
        code = 2'd3; deg = 3'd1; sigma1 = 10'h001; sigma2 = 10'd0; sigma3 = 10'd0; sigma4 = 10'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        pulses = 0; done_seen = 0;
        for (int k = 0; k <= 500; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("abort first loc_valid", {31'd0, loc_valid}, 1);
                check("abort first loc", {22'd0, loc}, 0);
            end
            if (loc_valid === 1'b1) pulses++;
            if (done === 1'b1) done_seen++;
            if (k == 100) begin
                code = 2'd1; sigma1 = 10'h001; deg = 3'd1; start = 1'b1;
            end
            if (k == 101) start = 1'b0;
            if (k == 400) check("abort still busy", {31'd0, busy}, 1);
            if (k == 500) rst = 1'b1;
        end
        check("abort pulses before rst", pulses, 1);
        check("abort done before rst", done_seen, 0);
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", {31'd0, busy}, 0);
        check("abort loc", {22'd0, loc}, 0);
        check("abort err_cnt", {29'd0, err_cnt}, 0);
        done_seen = 0; busy_seen = 0;
        for (int k = 0; k < 1100; k++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
            if (busy === 1'b1) busy_seen++;
        end
        check("abort no done", done_seen, 0);
        check("abort no busy", busy_seen, 0);

        // Reset wins over a simultaneous start.
        rst = 1'b1; start = 1'b1; code = 2'd1; deg = 3'd0; sigma1 = 10'd0;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst priority busy", {31'd0, busy}, 0);

        run_search("after", 2'd1, 3'd1, 10'h020, 10'h000, 10'h000, 10'h000, 5, -1, -1, -1, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
